// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared constants, matcher state encoding and the
// per-cycle step classification record used by count_monitor.
package count_monitor_pkg;

  localparam int unsigned CM_WIDTH = 5;   // monitored count width
  localparam int unsigned CM_WCNT  = 4;   // wrap counter width
  localparam int unsigned CM_HOLD  = 3;   // busy tail after a match
  localparam int unsigned CNT_MAX  = 31;  // last count before wrap-around

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Classification of the step from s3 (previous) to s2 (current)
  typedef struct packed {
    logic hold;
    logic legal;
    logic illegal;
    logic wrap;
  } step_t;

endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: bus between the ripple-counter side and the monitor.
//   count_in / target / arm : driven by the master (counter/test logic)
//   match / busy / wrap / wraps / err : driven by the monitor (slave)
interface count_monitor_if #(
  parameter int unsigned WIDTH = count_monitor_pkg::CM_WIDTH,
  parameter int unsigned WCNT  = count_monitor_pkg::CM_WCNT
) ();

  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] target;
  logic             arm;
  logic             match;
  logic             busy;
  logic             wrap;
  logic [WCNT-1:0]  wraps;
  logic             err;

  modport master (
    output count_in, target, arm,
    input  match, busy, wrap, wraps, err
  );

  modport slave (
    input  count_in, target, arm,
    output match, busy, wrap, wraps, err
  );

endinterface

// File: rtl/count_monitor_sync_pipe.sv
// sync_pipe: three-stage sampling register that brings the asynchronous
// ripple count into the clk domain and exposes the two settled stages.
//   clk    : system clock
//   clear  : synchronous active-low clear
//   i_d    : raw ripple count (may glitch between edges)
//   o_s2   : current settled value
//   o_s3   : previous settled value
module sync_pipe #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_s2,
  output logic [WIDTH-1:0] o_s3
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_s3;

  // s1 absorbs metastability/glitches; s2/s3 are the compared pair
  always_ff @(posedge clk) begin
    if (!clear) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_s2 = r_s2;
  assign o_s3 = r_s3;

endmodule

// File: rtl/count_monitor.sv
// count_monitor: re-samples a ripple counter, pulses wrap on 31->0,
// keeps a saturating wrap count, flags illegal steps (sticky err) and
// fires a one-shot match when an armed target value newly arrives.
//   clk   : system clock
//   clear : synchronous active-low reset
//   bus   : slave side of count_monitor_if (count_in/target/arm in,
//           match/busy/wrap/wraps/err out, all registered)
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = CM_WIDTH,
  parameter int unsigned HOLD  = CM_HOLD,
  parameter int unsigned WCNT  = CM_WCNT
) (
  input  logic           clk,
  input  logic           clear,
  count_monitor_if.slave bus
);

  localparam int unsigned HW = 4;  // hold counter width, covers 1..15

  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] w_s3;
  logic [WIDTH-1:0] w_s3_inc;
  step_t            w_step;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt_nxt;
  logic [HW-1:0]    r_hold_cnt;
  logic [HW-1:0]    w_hold_nxt;
  logic             r_match;
  logic             w_match_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic             r_wrap;
  logic [WCNT-1:0]  r_wraps;
  logic             r_err;

  sync_pipe #(.WIDTH(WIDTH)) u_sync_pipe (
    .clk   (clk),
    .clear (clear),
    .i_d   (bus.count_in),
    .o_s2  (w_s2),
    .o_s3  (w_s3)
  );

  // Step classification on the settled pair
  assign w_s3_inc = w_s3 + WIDTH'(1);

  always_comb begin
    w_step         = '0;
    w_step.hold    = (w_s2 == w_s3);
    w_step.legal   = (w_s2 == w_s3_inc);
    w_step.illegal = !w_step.hold && !w_step.legal;
    w_step.wrap    = (w_s3 == WIDTH'(CNT_MAX)) && (w_s2 == '0);
  end

  // Matcher state register
  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state    <= ST_IDLE;
      r_tgt      <= '0;
      r_hold_cnt <= '0;
      r_match    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_match    <= w_match_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Matcher next-state; only a legal step (a fresh arrival) can fire
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_hold_nxt  = r_hold_cnt;
    w_match_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (bus.arm) begin
          w_tgt_nxt   = bus.target;
          w_state_nxt = ST_ARMED;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_ARMED: begin
        if ((w_s2 == r_tgt) && w_step.legal) begin
          w_state_nxt = ST_FIRE;
          w_match_nxt = 1'b1;
        end
      end
      ST_FIRE: begin
        w_hold_nxt  = HW'(HOLD);
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_hold_nxt = r_hold_cnt - HW'(1);
        if (r_hold_cnt == HW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Wrap pulse, saturating wrap count and sticky error
  always_ff @(posedge clk) begin
    if (!clear) begin
      r_wrap  <= 1'b0;
      r_wraps <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wrap <= w_step.wrap;
      if (w_step.wrap && (r_wraps != '1)) begin
        r_wraps <= r_wraps + WCNT'(1);
      end
      if (w_step.illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.match = r_match;
  assign bus.busy  = r_busy;
  assign bus.wrap  = r_wrap;
  assign bus.wraps = r_wraps;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: self-checking bench for count_monitor. A transaction-
// level reference model predicts all outputs each cycle from the history
// of sampled counts and the arm/target requests.
module tb_count_monitor;

  localparam int HOLD = 3;

  logic clk;
  logic clear;
  int   n_chk;
  int   n_fail;
  int   cyc;

  count_monitor_if #(.WIDTH(5), .WCNT(4)) bus ();

  count_monitor #(.WIDTH(5), .HOLD(HOLD), .WCNT(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: last three sampled counts, oldest first
  int   m_h0, m_h1, m_h2;
  bit   e_match, e_busy, e_wrap, e_err, m_wait;
  int   e_wraps, m_tgt, m_remain;
  logic [7:0] expv;
  logic [7:0] obs;

  assign obs = {bus.match, bus.busy, bus.wrap, bus.wraps, bus.err};

  // Predict the effect of the coming edge from the current inputs
  task automatic model_edge();
    int  prev, cur;
    bit  same, legal;
    if (!clear) begin
      m_h0 = 0; m_h1 = 0; m_h2 = 0;
      e_match = 0; e_busy = 0; e_wrap = 0; e_err = 0; m_wait = 0;
      e_wraps = 0; m_tgt = 0; m_remain = 0;
    end else begin
      prev  = m_h0;
      cur   = m_h1;
      same  = (cur == prev);
      legal = (cur == (prev + 1) % 32);
      e_wrap = (prev == 31) && (cur == 0);
      if (e_wrap && e_wraps < 15) e_wraps++;
      if (!same && !legal) e_err = 1;
      e_match = 0;
      if (!e_busy) begin
        if (bus.arm) begin
          e_busy = 1; m_wait = 1; m_tgt = int'(bus.target);
        end
      end else if (m_wait) begin
        if (cur == m_tgt && legal) begin
          e_match = 1; m_wait = 0; m_remain = HOLD + 1;
        end
      end else begin
        m_remain--;
        if (m_remain == 0) e_busy = 0;
      end
      m_h0 = m_h1; m_h1 = m_h2; m_h2 = int'(bus.count_in);
    end
    expv = {e_match, e_busy, e_wrap, 4'(e_wraps), e_err};
  endtask

  // Drive one cycle of inputs, advance one edge, settle
  task automatic tick(input int c, input bit a, input int t);
    bus.count_in = 5'(c);
    bus.arm      = a;
    bus.target   = 5'(t);
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(7, 1, 3);
      n_chk++;
      if (obs !== 8'h00 || expv !== 8'h00) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b exp=00000000", cyc, obs);
      end
    end
    clear = 1'b1;
    tick(0, 0, 0);
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release cyc=%0d got=%b exp=00000000", cyc, obs);
    end
  endtask

  task automatic test_free_run();
    int nwrap;
    nwrap = 0;
    do_reset();
    for (int k = 0; k < 64 + 4; k++) begin
      for (int r = 0; r < 2; r++) begin
        tick((k < 64) ? (k % 32) : 0, 0, 0);
        if (bus.wrap) nwrap++;
        n_chk++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL free_run cyc=%0d got=%b exp=%b", cyc, obs, expv);
        end
      end
    end
    n_chk++;
    if (nwrap !== 2) begin
      n_fail++;
      $display("FAIL free_run_wrap_pulses got=%0d exp=2", nwrap);
    end
    n_chk++;
    if (bus.wraps !== 4'd2 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_final wraps=%0d err=%b exp wraps=2 err=0", bus.wraps, bus.err);
    end
  endtask

  task automatic test_match();
    int vals[$];
    int c5, c_match, c_fall, nmatch;
    bit busy_at_arm;
    vals = '{1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    c5 = -1; c_match = -1; c_fall = -1; nmatch = 0; busy_at_arm = 0;
    do_reset();
    for (int i = 0; i < vals.size(); i++) begin
      tick(vals[i], i == 4, (i == 4) ? 5 : 17);
      if (i == 4) busy_at_arm = bus.busy;
      if (vals[i] == 5 && c5 < 0) c5 = cyc;
      if (bus.match) begin nmatch++; c_match = cyc; end
      if (c_match >= 0 && c_fall < 0 && !bus.busy) c_fall = cyc;
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL match_seq cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    n_chk++;
    if (busy_at_arm !== 1'b1) begin
      n_fail++;
      $display("FAIL match_busy_rise got=%b exp=1", busy_at_arm);
    end
    n_chk++;
    if (nmatch != 1 || c_match != c5 + 2) begin
      n_fail++;
      $display("FAIL match_pulse count=%0d at=%0d exp count=1 at=%0d", nmatch, c_match, c5 + 2);
    end
    n_chk++;
    if (c_fall - c_match != HOLD + 1) begin
      n_fail++;
      $display("FAIL match_busy_fall got=%0d exp=%0d", c_fall - c_match, HOLD + 1);
    end
  endtask

  task automatic test_arm_current();
    int c_nine, c_match, nmatch;
    c_nine = -1; c_match = -1; nmatch = 0;
    do_reset();
    for (int v = 1; v <= 12; v++) tick((v <= 9) ? v : 9, 0, 0);
    tick(9, 1, 9);
    for (int i = 0; i < 40; i++) begin
      tick((10 + i) % 32, 0, 0);
      if (i == 31) c_nine = cyc;
      if (bus.match) begin nmatch++; c_match = cyc; end
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL arm_current cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    n_chk++;
    if (nmatch != 1 || c_match != c_nine + 2) begin
      n_fail++;
      $display("FAIL arm_current_lap count=%0d at=%0d exp count=1 at=%0d", nmatch, c_match, c_nine + 2);
    end
  endtask

  task automatic test_illegal();
    int vals[$];
    int c7;
    bit err_before, err_after;
    vals = '{1, 2, 3, 4, 7, 8, 9, 10, 11, 12};
    c7 = -1; err_before = 1; err_after = 0;
    do_reset();
    for (int i = 0; i < vals.size(); i++) begin
      tick(vals[i], 0, 0);
      if (vals[i] == 7) c7 = cyc;
      if (cyc == c7 + 1) err_before = bus.err;
      if (cyc == c7 + 2) err_after = bus.err;
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL illegal_seq cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    n_chk++;
    if (err_before !== 1'b0 || err_after !== 1'b1 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err got=%b%b%b exp=011", err_before, err_after, bus.err);
    end
    clear = 1'b0;
    tick(0, 0, 0);
    clear = 1'b1;
    n_chk++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear got=%b exp=0", bus.err);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit got;
    int v;
    got = 0; v = 3;
    do_reset();
    tick(1, 0, 0);
    tick(2, 0, 0);
    tick(2, 1, 4);
    for (int i = 0; i < 20 && !got; i++) begin
      tick(v, 0, 0);
      v = (v + 1) % 32;
      if (bus.match) got = 1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_hold_no_match got=0 exp=1");
    end
    tick(v, 0, 0);
    clear = 1'b0;
    tick(0, 0, 0);
    n_chk++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_hold_reset cyc=%0d got=%b exp=00000000", cyc, obs);
    end
    clear = 1'b1;
    tick(0, 1, 3);
    n_chk++;
    if (bus.busy !== 1'b1 || obs !== expv) begin
      n_fail++;
      $display("FAIL mid_hold_rearm cyc=%0d got=%b exp=%b", cyc, obs, expv);
    end
    for (int i = 1; i < 12; i++) begin
      tick(i, 0, 0);
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL mid_hold_after cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_wrap_saturate();
    int nwrap;
    bit both;
    nwrap = 0; both = 0;
    do_reset();
    tick(0, 0, 0);
    tick(0, 1, 0);
    for (int k = 1; k <= 17 * 32 + 3; k++) begin
      tick((k <= 17 * 32) ? (k % 32) : 0, 0, 0);
      if (bus.wrap) nwrap++;
      if (bus.match && bus.wrap) both = 1;
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL wrap_sat cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
    n_chk++;
    if (nwrap != 17 || bus.wraps !== 4'd15) begin
      n_fail++;
      $display("FAIL wrap_sat_count pulses=%0d wraps=%0d exp pulses=17 wraps=15", nwrap, bus.wraps);
    end
    n_chk++;
    if (!both) begin
      n_fail++;
      $display("FAIL wrap_and_match got=0 exp=1");
    end
  endtask

  task automatic test_random();
    int cur, r, t;
    bit a;
    cur = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        clear = 1'b0;
        tick(cur, 0, 0);
        clear = 1'b1;
        cur = 0;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 70) cur = (cur + 1) % 32;
        else if (r >= 95) cur = $urandom_range(0, 31);
        a = ($urandom_range(0, 9) == 0);
        t = (r < 50) ? (cur + $urandom_range(1, 6)) % 32 : $urandom_range(0, 31);
        tick(cur, a, t);
      end
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    clear = 1'b0;
    bus.count_in = '0;
    bus.arm = 1'b0;
    bus.target = '0;
    expv = '0;
    test_reset();
    test_free_run();
    test_match();
    test_arm_current();
    test_illegal();
    test_reset_mid_hold();
    test_wrap_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
